d_ff_pipe: RTL and testbench

- Parametrised register pipeline: a DEPTH-stage delay line of WIDTH-bit flip-flops.
- Adds a per-stage valid bit, a stall/advance enable, a synchronous flush and an occupancy counter.
- Generalises the single asynchronous-reset D flip-flop used across the design.
- Used to retime buses, and to align data paths with control paths of known latency.

---
 rtl/d_ff_pipe.sv | 76 +++++++
 tb/tb_d_ff_pipe.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/d_ff_pipe.sv
// d_ff_pipe: DEPTH-stage WIDTH-bit delay line with per-stage valid, advance enable,
// synchronous flush and occupancy count. Optional macro: D_FF_PIPE_ZERO_INVALID_EN.
module d_ff_pipe #(
  parameter int                 WIDTH     = 8,
  parameter int                 DEPTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
  localparam int                OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [OCC_W-1:0] occupancy
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [OCC_W-1:0] r_occ;

  logic [WIDTH-1:0] w_data_in [DEPTH];
  logic [DEPTH-1:0] w_valid_in;
  logic [WIDTH-1:0] w_stage0;
  logic [OCC_W-1:0] w_occ_next;

`ifdef D_FF_PIPE_ZERO_INVALID_EN
  // Invalid words enter as RESET_VAL so nothing toggles downstream while q_valid=0.
  assign w_stage0 = d_valid ? d : RESET_VAL;
`else
  assign w_stage0 = d;
`endif

  // Shift-in value for every stage; stage 0 is fed from the input port.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign w_data_in[gi]  = w_stage0;
      assign w_valid_in[gi] = d_valid;
    end else begin : g_body
      assign w_data_in[gi]  = r_data[gi-1];
      assign w_valid_in[gi] = r_valid[gi-1];
    end
  end

  // Entry and exit on the same edge cancel, keeping occupancy within 0..DEPTH.
  assign w_occ_next = r_occ + OCC_W'(d_valid) - OCC_W'(r_valid[DEPTH-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= RESET_VAL;
      end
      r_valid <= '0;
      r_occ   <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= RESET_VAL;
      end
      r_valid <= '0;
      r_occ   <= '0;
    end else if (en) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= w_data_in[i];
      end
      r_valid <= w_valid_in;
      r_occ   <= w_occ_next;
    end
  end

  assign q         = r_data[DEPTH-1];
  assign q_valid   = r_valid[DEPTH-1];
  assign occupancy = r_occ;

endmodule

// File: tb/tb_d_ff_pipe.sv
// tb_d_ff_pipe: directed bench for d_ff_pipe (WIDTH=8, DEPTH=4) with a reference
// pipeline model plus a scoreboard of accepted words tagged with their due edge.
module tb_d_ff_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam logic [WIDTH-1:0] RV = 8'h00;

  logic             clk;
  logic             reset;
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [2:0]       occupancy;

  d_ff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
    .q(q), .q_valid(q_valid), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               due;
  } sb_t;

  sb_t              sb[$];
  logic [WIDTH-1:0] md [DEPTH];
  logic [DEPTH-1:0] mv;
  int               ecount;
  int               errors;
  int               checks;
  logic [WIDTH-1:0] exp_inv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) md[i] = RV;
    mv = '0;
    sb.delete();
  endtask

  task automatic check_outputs(input bit adv_edge);
    sb_t e;
    check("q_valid", 32'(q_valid), 32'(mv[DEPTH-1]));
    check("q", 32'(q), 32'(md[DEPTH-1]));
    check("occupancy", 32'(occupancy), 32'($countones(mv)));
    if (adv_edge && mv[DEPTH-1]) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_data", 32'(q), 32'(e.data));
        check("sb_latency", 32'(ecount), 32'(e.due));
      end
    end
  endtask

  // One clock edge with the given controls, model update, then sampling 1 ns later.
  task automatic step(input logic e, input logic c, input logic dv, input logic [WIDTH-1:0] dd);
    en = e; clr = c; d_valid = dv; d = dd;
    @(posedge clk);
    if (reset || c) begin
      model_reset();
    end else if (e) begin
      ecount++;
      for (int i = DEPTH - 1; i > 0; i--) begin
        md[i] = md[i-1];
        mv[i] = mv[i-1];
      end
`ifdef D_FF_PIPE_ZERO_INVALID_EN
      md[0] = dv ? dd : RV;
`else
      md[0] = dd;
`endif
      mv[0] = dv;
      if (dv) sb.push_back('{data: dd, due: ecount + DEPTH - 1});
    end
    #1;
    $display("t=%0t en=%0b clr=%0b d=%02h dv=%0b -> q=%02h qv=%0b occ=%0d",
             $time, e, c, dd, dv, q, q_valid, occupancy);
    check_outputs(e && !c && !reset);
  endtask

  initial begin
    errors = 0; checks = 0; ecount = 0;
    model_reset();
`ifdef D_FF_PIPE_ZERO_INVALID_EN
    exp_inv = RV;
`else
    exp_inv = 8'h3C;
`endif

    // 1: reset held 100 ns with active inputs; outputs must stay cleared.
    reset = 1'b1; en = 1'b1; clr = 1'b0; d = 8'hA5; d_valid = 1'b1;
    #1;
    check_outputs(1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_outputs(1'b0);
    end
    reset = 1'b0;

    // 2: fill with 01..05.
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 1'b1, 8'(i));

    // 3: stream 10..13 with stalls on edges 2 and 3, then drain.
    step(1'b1, 1'b0, 1'b1, 8'h10);
    step(1'b0, 1'b0, 1'b1, 8'h77);
    step(1'b0, 1'b0, 1'b1, 8'h78);
    step(1'b1, 1'b0, 1'b1, 8'h11);
    step(1'b1, 1'b0, 1'b1, 8'h12);
    step(1'b1, 1'b0, 1'b1, 8'h13);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'h00);

    // 4: fill, then flush with a valid FF on the same edge.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h20 + i));
    check("full_before_clr", 32'(occupancy), 32'd4);
    step(1'b1, 1'b1, 1'b1, 8'hFF);
    check("clr_occ", 32'(occupancy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'h00);
      check("no_ff_after_clr", 32'(q != 8'hFF), 32'd1);
    end

    // 5: fill, then assert reset between edges with no clock.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h30 + i));
    check("full_before_reset", 32'(occupancy), 32'd4);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs(1'b0);
    #1;
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 1'b1, 8'(i));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h00);

    // 6: constant 3C with alternating valid.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, ((i % 2) == 0), 8'h3C);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, ((i % 2) == 0), 8'h3C);
      check("alt_q", 32'(q), 32'(q_valid ? 8'h3C : exp_inv));
      check("alt_occ", 32'(occupancy), 32'd2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
